// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad encoder.
package keypad_pkg;

  // Scanner/debouncer FSM states.
  typedef enum logic [2:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB,
    POST
  } kp_state_t;

  // Function keys decoded by the downstream lock logic.
  localparam logic [3:0] KEY_CLEAR = 4'd7;
  localparam logic [3:0] KEY_PROG  = 4'd8;
  localparam logic [3:0] KEY_LOCK  = 4'd9;

  // Key code indexed as KEY_MAP[row][col].
  localparam logic [0:3][0:3][3:0] KEY_MAP = '{
    '{4'd1,  4'd2, 4'd3,  4'd10},
    '{4'd4,  4'd5, 4'd6,  4'd11},
    '{4'd7,  4'd8, 4'd9,  4'd12},
    '{4'd14, 4'd0, 4'd15, 4'd13}
  };

  // Index of the lowest-numbered row reading low (rows are active-low).
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[2]) idx = 2'd2;
    if (!rows[1]) idx = 2'd1;
    if (!rows[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; idles high.
module row_sync (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_reg;
  logic [3:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      // Per-row two-stage capture; reset to the released (high) level.
      always_ff @(posedge hwclk) begin
        if (reset) begin
          meta_reg[gi] <= 1'b1;
          sync_reg[gi] <= 1'b1;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner with single-key press/release debouncing.
// Produces button/bstate/readInput for the lock datapath and a press strobe.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1200,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int POST_HOLD       = 4
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] button,
  output logic       bstate,
  output logic       readInput,
  output logic       key_strobe
);

  localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int POST_W = $clog2(POST_HOLD) + 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_HOLD - 1);

  logic [3:0]        row_s;
  kp_state_t         state_reg;
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic [POST_W-1:0] post_cnt_reg;
  logic [1:0]        col_idx_reg;
  logic [3:0]        col_out_reg;
  logic [1:0]        lat_row_reg;
  logic [1:0]        lat_col_reg;
  logic [3:0]        button_reg;
  logic              bstate_reg;
  logic              read_reg;
  logic              strobe_reg;
  logic              lat_row_high;

  row_sync u_row_sync (
    .hwclk (hwclk),
    .reset (reset),
    .d     (row_in),
    .q     (row_s)
  );

  // Only the latched key's row matters once a key has been picked.
  assign lat_row_high = row_s[lat_row_reg];

  // Scan, debounce and output sequencing. Counters stop at their terminal
  // value, so they can never wrap. Leaving PRESS_DB or POST resumes
  // scanning at the column after the frozen one.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_reg    <= SCAN;
      scan_cnt_reg <= '0;
      db_cnt_reg   <= '0;
      post_cnt_reg <= '0;
      col_idx_reg  <= 2'd0;
      col_out_reg  <= 4'b1110;
      lat_row_reg  <= 2'd0;
      lat_col_reg  <= 2'd0;
      button_reg   <= 4'd0;
      bstate_reg   <= 1'b0;
      read_reg     <= 1'b0;
      strobe_reg   <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            if (row_s != 4'hF) begin
              lat_row_reg <= lowest_low_row(row_s);
              lat_col_reg <= col_idx_reg;
              db_cnt_reg  <= '0;
              state_reg   <= PRESS_DB;
            end else begin
              col_idx_reg <= col_idx_reg + 2'd1;
              col_out_reg <= {col_out_reg[2:0], col_out_reg[3]};
            end
          end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
          end
        end
        PRESS_DB: begin
          if (lat_row_high) begin
            scan_cnt_reg <= '0;
            col_idx_reg  <= col_idx_reg + 2'd1;
            col_out_reg  <= {col_out_reg[2:0], col_out_reg[3]};
            state_reg    <= SCAN;
          end else if (db_cnt_reg == DB_LAST) begin
            button_reg <= KEY_MAP[lat_row_reg][lat_col_reg];
            bstate_reg <= 1'b1;
            read_reg   <= 1'b1;
            strobe_reg <= 1'b1;
            state_reg  <= HELD;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        HELD: begin
          if (lat_row_high) begin
            db_cnt_reg <= '0;
            state_reg  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!lat_row_high) begin
            state_reg <= HELD;
          end else if (db_cnt_reg == DB_LAST) begin
            bstate_reg   <= 1'b0;
            post_cnt_reg <= '0;
            state_reg    <= POST;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        POST: begin
          if (post_cnt_reg == POST_LAST) begin
            read_reg     <= 1'b0;
            scan_cnt_reg <= '0;
            col_idx_reg  <= col_idx_reg + 2'd1;
            col_out_reg  <= {col_out_reg[2:0], col_out_reg[3]};
            state_reg    <= SCAN;
          end else begin
            post_cnt_reg <= post_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign col_out    = col_out_reg;
  assign button     = button_reg;
  assign bstate     = bstate_reg;
  assign readInput  = read_reg;
  assign key_strobe = strobe_reg;

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder: emulated keypad matrix, timestamp-based
// reference model, directed scenarios plus randomized key sessions.
module tb_keypad_encoder;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int PH = 2;

  localparam int P_SCAN  = 0;
  localparam int P_PRESS = 1;
  localparam int P_HELD  = 2;
  localparam int P_REL   = 3;
  localparam int P_POST  = 4;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out;
  logic [3:0] button;
  logic       bstate;
  logic       readInput;
  logic       key_strobe;

  keypad_encoder #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DB),
    .POST_HOLD       (PH)
  ) dut (
    .hwclk      (hwclk),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .button     (button),
    .bstate     (bstate),
    .readInput  (readInput),
    .key_strobe (key_strobe)
  );

  always #5 hwclk = ~hwclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d time=%0t", tag, obs, exp, $time);
    end
  endtask

  // Physical keypad: bit r*4+c is set while that key is closed.
  logic [15:0] pressed = '0;
  int code_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  function automatic logic [3:0] keypad_rows(input logic [3:0] cols, input logic [15:0] keys);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 16; i++)
      if (keys[i] && (cols[i % 4] === 1'b0)) r[i / 4] = 1'b0;
    return r;
  endfunction

  // Reference model state: phases with entry timestamps.
  int         mcyc = 0;
  int         m_phase = P_SCAN;
  int         m_col = 0;
  int         col0 = 0;
  int         t_scan = 0;
  int         t_phase = 0;
  int         lat_r = 0;
  int         lat_c = 0;
  int         m_button = 0;
  bit         m_bstate = 0;
  bit         m_ri = 0;
  bit         m_strobe = 0;
  bit         m_valid = 0;
  logic [3:0] h1 = 4'hF;
  logic [3:0] h2 = 4'hF;

  task automatic model_step(input logic [3:0] rin, input logic rst);
    logic [3:0] s;
    int cur;
    mcyc++;
    if (rst) begin
      m_valid = 1; m_phase = P_SCAN; m_col = 0; col0 = 0; t_scan = mcyc;
      m_button = 0; m_bstate = 0; m_ri = 0; m_strobe = 0; h1 = 4'hF; h2 = 4'hF;
      return;
    end
    s = h2; h2 = h1; h1 = rin;
    m_strobe = 0;
    case (m_phase)
      P_SCAN: begin
        if ((mcyc - t_scan) % SD == 0) begin
          cur = (col0 + (mcyc - t_scan - 1) / SD) % 4;
          if (s != 4'hF) begin
            for (int r = 3; r >= 0; r--) if (!s[r]) lat_r = r;
            lat_c = cur; m_col = cur; m_phase = P_PRESS; t_phase = mcyc;
          end else begin
            m_col = (col0 + (mcyc - t_scan) / SD) % 4;
          end
        end
      end
      P_PRESS: begin
        if (s[lat_r]) begin
          m_phase = P_SCAN; col0 = (lat_c + 1) % 4; t_scan = mcyc; m_col = col0;
        end else if (mcyc - t_phase == DB) begin
          m_button = code_tab[lat_r * 4 + lat_c];
          m_bstate = 1; m_ri = 1; m_strobe = 1; m_phase = P_HELD;
        end
      end
      P_HELD: begin
        if (s[lat_r]) begin m_phase = P_REL; t_phase = mcyc; end
      end
      P_REL: begin
        if (!s[lat_r]) m_phase = P_HELD;
        else if (mcyc - t_phase == DB) begin m_bstate = 0; m_phase = P_POST; t_phase = mcyc; end
      end
      default: begin
        if (mcyc - t_phase == PH) begin
          m_ri = 0; m_phase = P_SCAN; col0 = (lat_c + 1) % 4; t_scan = mcyc; m_col = col0;
        end
      end
    endcase
  endtask

  int strobes = 0;
  int rises = 0;
  int falls = 0;
  bit prev_b = 0;

  // One clock: drive rows from the keypad, step the model, compare.
  task automatic tick();
    logic [3:0] rin_s;
    logic       rst_s;
    logic [3:0] exp_col;
    row_in = keypad_rows(col_out, pressed);
    rin_s = row_in;
    rst_s = reset;
    @(posedge hwclk);
    model_step(rin_s, rst_s);
    #1;
    if (m_valid) begin
      exp_col = 4'hF & ~(4'b0001 << m_col);
      check_val("col_out", int'(col_out), int'(exp_col));
      check_val("button", int'(button), m_button);
      check_val("bstate", int'(bstate), int'(m_bstate));
      check_val("readInput", int'(readInput), int'(m_ri));
      check_val("key_strobe", int'(key_strobe), int'(m_strobe));
    end
    if (key_strobe === 1'b1) begin
      strobes++;
      $display("key accepted: button=%0d cycle=%0d", button, mcyc);
    end
    if (prev_b && (bstate === 1'b0)) falls++;
    if (!prev_b && (bstate === 1'b1)) rises++;
    prev_b = (bstate === 1'b1);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_counts();
    strobes = 0; rises = 0; falls = 0;
  endtask

  initial begin
    int k, k2, hold, noisy;

    // Reset and idle scanning.
    reset = 1'b1;
    run(3);
    check_val("rst_col", int'(col_out), 4'hE);
    check_val("rst_button", int'(button), 0);
    check_val("rst_bstate", int'(bstate), 0);
    check_val("rst_read", int'(readInput), 0);
    reset = 1'b0;
    run(1);
    check_val("rst_col_next", int'(col_out), 4'hE);
    run(20);
    $display("scenario idle_scan done");

    // Clean press of key 8 (row2/col1).
    clr_counts();
    pressed[2 * 4 + 1] = 1'b1;
    run(40);
    check_val("clean_button", int'(button), 8);
    check_val("clean_bstate_held", int'(bstate), 1);
    pressed = '0;
    run(30);
    check_val("clean_strobes", strobes, 1);
    check_val("clean_falls", falls, 1);
    check_val("clean_read_end", int'(readInput), 0);
    check_val("clean_button_end", int'(button), 8);
    $display("scenario clean_press done strobes=%0d", strobes);

    // Press and release bounce on key 5 (row1/col1).
    clr_counts();
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) pressed[1 * 4 + 1] = ~pressed[1 * 4 + 1];
      tick();
    end
    pressed[1 * 4 + 1] = 1'b1;
    run(40);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) pressed[1 * 4 + 1] = ~pressed[1 * 4 + 1];
      tick();
    end
    pressed = '0;
    run(40);
    check_val("bounce_strobes", strobes, 1);
    check_val("bounce_rises", rises, 1);
    check_val("bounce_falls", falls, 1);
    check_val("bounce_button", int'(button), 5);
    $display("scenario bounce done strobes=%0d", strobes);

    // Second key while the first is held.
    clr_counts();
    pressed[0] = 1'b1;
    run(40);
    pressed[3 * 4 + 2] = 1'b1;
    run(20);
    check_val("second_button_hold", int'(button), 1);
    pressed[0] = 1'b0;
    run(60);
    check_val("second_button_new", int'(button), 15);
    check_val("second_strobes", strobes, 2);
    pressed = '0;
    run(40);
    $display("scenario second_key done strobes=%0d", strobes);

    // Reset while key 9 (row2/col2) is held.
    pressed[2 * 4 + 2] = 1'b1;
    run(40);
    check_val("midrst_held", int'(bstate), 1);
    reset = 1'b1;
    run(1);
    check_val("midrst_bstate", int'(bstate), 0);
    check_val("midrst_read", int'(readInput), 0);
    check_val("midrst_button", int'(button), 0);
    check_val("midrst_col", int'(col_out), 4'hE);
    reset = 1'b0;
    clr_counts();
    run(40);
    check_val("midrst_redetect", strobes, 1);
    check_val("midrst_button_new", int'(button), 9);
    pressed = '0;
    run(40);
    $display("scenario reset_mid_held done strobes=%0d", strobes);

    // 5-cycle glitch on row1 in every column.
    clr_counts();
    pressed[7:4] = 4'hF;
    run(5);
    pressed = '0;
    run(30);
    check_val("glitch_strobes", strobes, 0);
    check_val("glitch_read", int'(readInput), 0);
    check_val("glitch_button", int'(button), 9);
    $display("scenario glitch done strobes=%0d", strobes);

    // Randomized sessions against the model.
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 15);
      noisy = $urandom_range(0, 1);
      hold = $urandom_range(2, 45);
      if (noisy != 0)
        for (int i = 0; i < 10; i++) begin
          pressed[k] = 1'($urandom_range(0, 1));
          tick();
        end
      pressed[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        k2 = $urandom_range(0, 15);
        pressed[k2] = 1'b1;
      end
      run(hold);
      if (noisy != 0)
        for (int i = 0; i < 10; i++) begin
          pressed[k] = 1'($urandom_range(0, 1));
          tick();
        end
      pressed = '0;
      run($urandom_range(10, 40));
      $display("random session %0d key=%0d hold=%0d noisy=%0d", it, code_tab[k], hold, noisy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
